dplca_txop_claim_tracker: RTL

//  Builds and ages the D-PLCA TXOP claim table consumed by the D-PLCA control state machine (148.8).
//  - Observes received PLCA commands and the end of each transmit opportunity (TO).
//  - Records which TO IDs are claimed by transmitting nodes.
//  - Signals each completed beacon cycle (dplca_txop_table_upd) and each aging step (dplca_new_age).
//  - Sits between the PLCA RS receive path and the 148.8 control machine; synthesizable, one clock.

---
 rtl/dplca_txop_claim_tracker_if.sv | 26 ++
 rtl/dplca_txop_claim_tracker.sv | 87 ++++++++
 2 files changed

// File: rtl/dplca_txop_claim_tracker_if.sv
// D-PLCA TXOP claim tracker bus: receive-path observations in, claim table and pulses out.
interface dplca_txop_claim_tracker_if;
    logic         dplca_en;
    logic         dplca_aging;
    logic         plca_status;
    logic [1:0]   rx_cmd;
    logic [7:0]   curID;
    logic         to_done;
    logic         to_active;
    logic [511:0] txop_claim_table_unpacked;
    logic         dplca_txop_table_upd;
    logic         dplca_new_age;
    logic [8:0]   dplca_claim_count;

    // Side that drives the observations (PLCA RS receive path / 148.8 machine)
    modport master (
        output dplca_en, dplca_aging, plca_status, rx_cmd, curID, to_done, to_active,
        input  txop_claim_table_unpacked, dplca_txop_table_upd, dplca_new_age, dplca_claim_count
    );

    // Side that owns the claim table (the tracker itself)
    modport slave (
        input  dplca_en, dplca_aging, plca_status, rx_cmd, curID, to_done, to_active,
        output txop_claim_table_unpacked, dplca_txop_table_upd, dplca_new_age, dplca_claim_count
    );
endinterface

// File: rtl/dplca_txop_claim_tracker.sv
// D-PLCA TXOP claim tracker: records which TO IDs are claimed, counts beacon
// cycles, ages the table every AGE_CYCLES beacons and reports the claim count.
module dplca_txop_claim_tracker #(
    parameter int AGE_CYCLES = 8,
    parameter int CLAIM_MAX  = 3
) (
    input logic                         clk,
    input logic                         reset_n,
    dplca_txop_claim_tracker_if.slave   bus
);

    localparam logic [1:0] CMD_BEACON = 2'b00;
    localparam logic [1:0] CLAIM_VAL  = 2'(CLAIM_MAX);
    localparam logic [7:0] AGE_LAST   = 8'(AGE_CYCLES - 1);

    logic [511:0] table_q;
    logic         prev_beacon;
    logic [7:0]   age_cnt;
    logic         upd_q;
    logic         new_age_q;
    logic [8:0]   count_q;
    logic [8:0]   count_next;

    logic clear;
    logic bcn_edge;
    logic claim;
    logic age_step;

    // dplca_en low wipes table state exactly like reset, without being a reset port
    assign clear    = !reset_n || !bus.dplca_en;
    assign bcn_edge = (bus.rx_cmd == CMD_BEACON) && !prev_beacon;
    assign claim    = bus.to_done && bus.to_active && bus.plca_status;
    assign age_step = bcn_edge && bus.dplca_aging && (age_cnt == AGE_LAST);

    // Beacon edge detection, cycle counting and the registered upd/new_age pulses
    always_ff @(posedge clk) begin
        if (clear) begin
            prev_beacon <= 1'b1;
            age_cnt     <= '0;
            upd_q       <= 1'b0;
            new_age_q   <= 1'b0;
        end else begin
            prev_beacon <= (bus.rx_cmd == CMD_BEACON);
            upd_q       <= bcn_edge;
            new_age_q   <= age_step;
            if (bcn_edge && bus.dplca_aging) begin
                age_cnt <= age_step ? 8'd0 : age_cnt + 8'd1;
            end
        end
    end

    // Claim table update: a claim on this cycle beats a simultaneous aging decrement
    always_ff @(posedge clk) begin
        for (int i = 0; i < 256; i++) begin
            if (clear) begin
                table_q[2*i +: 2] <= 2'd0;
            end else if (claim && (bus.curID == 8'(i))) begin
                table_q[2*i +: 2] <= CLAIM_VAL;
            end else if (age_step && (table_q[2*i +: 2] != 2'd0)) begin
                table_q[2*i +: 2] <= table_q[2*i +: 2] - 2'd1;
            end
        end
    end

    // Population count of nonzero entries in the current table
    always_comb begin
        count_next = '0;
        for (int i = 0; i < 256; i++) begin
            count_next = count_next + 9'(|table_q[2*i +: 2]);
        end
    end

    // Registered claim count, one cycle behind the table
    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign bus.txop_claim_table_unpacked = table_q;
    assign bus.dplca_txop_table_upd      = upd_q;
    assign bus.dplca_new_age             = new_age_q;
    assign bus.dplca_claim_count         = count_q;

endmodule
